// File: rtl/usb_packet_arbiter.sv
// rtl/usb_packet_arbiter.sv - packet-atomic round-robin arbiter sharing one USB FIFO stream
module usb_packet_arbiter #(
  parameter int NUM_SOURCES = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  localparam int ID_W       = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SOURCES-1:0]            s_tvalid,
  input  logic [NUM_SOURCES-1:0]            s_tlast,
  output logic [NUM_SOURCES-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic                              m_tvalid,
  output logic                              m_tlast,
  input  logic                              m_tready,
  output logic                              grant_valid,
  output logic [ID_W-1:0]                   grant_id,
  output logic [NUM_SOURCES*CNT_WIDTH-1:0]  pkt_count
);

  typedef enum logic {ARB_IDLE, ARB_FORWARD} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       pick;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  out_free;
  logic                  accept;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_SOURCES];

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_cnt
    assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  assign out_free = !m_tvalid || m_tready;

  always_comb begin
    state_d    = state_q;
    s_tready   = '0;
    pick       = '0;
    pick_found = 1'b0;
    sel_data   = '0;
    sel_last   = 1'b0;
    sel_valid  = 1'b0;
    accept     = 1'b0;

    // Round-robin scan: sources above last_grant first, then wrap to 0..last_grant.
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!pick_found && s_tvalid[i] && (ID_W'(i) > last_grant)) begin
        pick_found = 1'b1;
        pick       = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (!pick_found && s_tvalid[i] && (ID_W'(i) <= last_grant)) begin
        pick_found = 1'b1;
        pick       = ID_W'(i);
      end
    end

    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last  = s_tlast[i];
        sel_valid = s_tvalid[i];
      end
    end

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) state_d = ARB_FORWARD;
      end
      ARB_FORWARD: begin
        s_tready[grant_id] = out_free;
        accept             = sel_valid && out_free;
        if (accept && sel_last) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      m_tdata     <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_grant  <= ID_W'(NUM_SOURCES - 1);
      for (int i = 0; i < NUM_SOURCES; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && pick_found) begin
        grant_id    <= pick;
        grant_valid <= 1'b1;
      end
      if (accept) begin
        m_tdata  <= sel_data;
        m_tlast  <= sel_last;
        m_tvalid <= 1'b1;
        if (sel_last) begin
          last_grant       <= grant_id;
          cnt_q[grant_id]  <= cnt_q[grant_id] + 1'b1;
          grant_valid      <= 1'b0;
        end
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule
